// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-path definitions: word width, NOP encoding and the queued fetch-entry layout.
package instruction_fetch_unit_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
    localparam int ENTRY_W = 2 * XLEN;

    // pc occupies the upper XLEN bits of an entry, the instruction the lower XLEN bits
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO for fetch entries; flush empties it and wins over a same-cycle push.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] storage [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = push & (~full | pop);
    assign rd_en = pop & ~empty;
    assign dout  = storage[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                storage[wr_ptr] <= din;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads the zero-latency instruction memory and queues {pc, instr} for decode.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        misaligned_err
);

    logic [XLEN-1:0] pc;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    fetch_entry_t    wr_entry;
    fetch_entry_t    head;

    assign imem_addr = pc;
    assign if_valid  = ~empty;
    assign pop       = if_valid & if_ready;
    // A redirect kills this cycle's fetch; otherwise fetch whenever a slot is or becomes free
    assign push      = ~redirect_valid & (~full | pop);
    assign wr_entry  = '{pc: pc, instr: imem_instr};
    assign if_instr  = head.instr;
    assign if_pc     = head.pc;

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (wr_entry),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc             <= RESET_PC;
            misaligned_err <= 1'b0;
        end else begin
            misaligned_err <= redirect_valid & (|redirect_pc[1:0]);
            if (redirect_valid) begin
                pc <= align_word(redirect_pc);
            end else if (push) begin
                pc <= pc + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a queue-based reference model of the fetch stream.
module tb_instruction_fetch_unit;
    import instruction_fetch_unit_pkg::*;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RPC_HIGH = 32'hFFFF_FFF8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n, rst2_n;
    logic        redirect_valid, redirect_pc_dummy;
    logic [31:0] redirect_pc;
    logic        if_ready;
    logic [31:0] imem_addr, imem_instr, if_instr, if_pc;
    logic        if_valid, misaligned_err;

    logic        rv2, rdy2;
    logic [31:0] rp2;
    logic [31:0] imem_addr2, imem_instr2, if_instr2, if_pc2;
    logic        if_valid2, misaligned_err2;

    int tests = 0;
    int fails = 0;

    ent_t        mq[$];
    logic [31:0] mpc;
    logic        merr;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a >= 32'd64) return ~a;
        case (a[5:2])
            4'd0:    return 32'h0050_0093;
            4'd1:    return 32'h00a0_0113;
            4'd2:    return 32'h0020_81b3;
            4'd4:    return 32'h0000_2283;
            default: return INSTR_NOP | {a[19:0], 12'h000};
        endcase
    endfunction

    assign imem_instr  = mem_rd(imem_addr);
    assign imem_instr2 = mem_rd(imem_addr2);

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .misaligned_err(misaligned_err)
    );

    instruction_fetch_unit #(.RESET_PC(RPC_HIGH), .FIFO_DEPTH(DEPTH)) dut_high (
        .clk(clk), .rst_n(rst2_n), .imem_addr(imem_addr2), .imem_instr(imem_instr2),
        .redirect_valid(rv2), .redirect_pc(rp2),
        .if_valid(if_valid2), .if_ready(rdy2), .if_instr(if_instr2), .if_pc(if_pc2),
        .misaligned_err(misaligned_err2)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mpc  = 32'h0000_0000;
        merr = 1'b0;
    endtask

    // One clock edge of the fetch stage, described as a stream of fetched words
    task automatic model_edge(input logic rv, input logic [31:0] rp, input logic rdy);
        if (mq.size() != 0 && rdy) void'(mq.pop_front());
        if (rv) begin
            mq.delete();
            mpc  = {rp[31:2], 2'b00};
            merr = (rp[1:0] != 2'b00);
        end else begin
            merr = 1'b0;
            if (mq.size() < DEPTH) begin
                mq.push_back('{pc: mpc, instr: mem_rd(mpc)});
                mpc = mpc + 32'd4;
            end
        end
    endtask

    task automatic compare();
        chk("model_valid", {31'd0, if_valid}, {31'd0, mq.size() != 0});
        chk("model_addr", imem_addr, mpc);
        chk("model_err", {31'd0, misaligned_err}, {31'd0, merr});
        if (mq.size() != 0 && if_valid) begin
            chk("model_pc", if_pc, mq[0].pc);
            chk("model_instr", if_instr, mq[0].instr);
        end
    endtask

    // Called at a falling edge: apply inputs, advance one rising edge, check at the next falling edge
    task automatic step(input logic rv, input logic [31:0] rp, input logic rdy);
        redirect_valid = rv;
        redirect_pc    = rp;
        if_ready       = rdy;
        @(posedge clk);
        model_edge(rv, rp, rdy);
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        redirect_valid = 1'b0;
        if_ready       = 1'b0;
        @(negedge clk);
        compare();
        rst_n = 1'b1;
    endtask

    logic [15:0] rdy_pat;

    initial begin
        redirect_pc_dummy = 1'b0;
        rst_n = 1'b0; rst2_n = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b1;
        rv2 = 1'b0; rp2 = '0; rdy2 = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);

        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_instr", if_instr, 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_err", {31'd0, misaligned_err}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        rst_n = 1'b1;

        step(1'b0, 32'd0, 1'b1);
        chk("t1_valid", {31'd0, if_valid}, 32'd1);
        chk("t1_pc0", if_pc, 32'h0);
        chk("t1_i0", if_instr, 32'h0050_0093);
        step(1'b0, 32'd0, 1'b1);
        chk("t1_pc4", if_pc, 32'h4);
        chk("t1_i4", if_instr, 32'h00a0_0113);
        step(1'b0, 32'd0, 1'b1);
        chk("t1_pc8", if_pc, 32'h8);
        chk("t1_i8", if_instr, 32'h0020_81b3);

        do_reset();
        repeat (6) step(1'b0, 32'd0, 1'b0);
        chk("t2_valid", {31'd0, if_valid}, 32'd1);
        chk("t2_addr", imem_addr, 32'h8);
        chk("t2_head0", if_pc, 32'h0);
        step(1'b0, 32'd0, 1'b1);
        chk("t2_head4", if_pc, 32'h4);
        step(1'b0, 32'd0, 1'b1);
        chk("t2_head8", if_pc, 32'h8);
        step(1'b0, 32'd0, 1'b1);
        chk("t2_headC", if_pc, 32'hC);

        repeat (2) step(1'b0, 32'd0, 1'b0);
        step(1'b1, 32'h10, 1'b0);
        chk("t3_flush_valid", {31'd0, if_valid}, 32'd0);
        chk("t3_addr", imem_addr, 32'h10);
        step(1'b0, 32'd0, 1'b0);
        chk("t3_pc", if_pc, 32'h10);
        chk("t3_instr", if_instr, 32'h0000_2283);

        step(1'b1, 32'h16, 1'b1);
        chk("t4_err_hi", {31'd0, misaligned_err}, 32'd1);
        chk("t4_addr", imem_addr, 32'h14);
        step(1'b0, 32'd0, 1'b1);
        chk("t4_err_lo", {31'd0, misaligned_err}, 32'd0);
        chk("t4_pc", if_pc, 32'h14);

        step(1'b1, 32'h20, 1'b1);
        step(1'b1, 32'h30, 1'b1);
        step(1'b0, 32'd0, 1'b1);
        chk("b2b_pc", if_pc, 32'h30);

        rdy_pat = 16'b1011_0010_1110_0110;
        for (int i = 0; i < 16; i++) step(1'b0, 32'd0, rdy_pat[i]);
        step(1'b1, 32'h3C, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 32'd0, rdy_pat[i]);

        repeat (3) step(1'b0, 32'd0, 1'b0);
        chk("t6_full_valid", {31'd0, if_valid}, 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_valid", {31'd0, if_valid}, 32'd0);
        chk("t6_async_addr", imem_addr, 32'd0);
        model_reset();
        @(negedge clk);
        compare();
        rst_n = 1'b1;
        step(1'b0, 32'd0, 1'b1);
        chk("t6_restart_pc", if_pc, 32'h0);
        chk("t6_restart_instr", if_instr, 32'h0050_0093);

        rst2_n = 1'b1;
        @(negedge clk);
        chk("t5_valid", {31'd0, if_valid2}, 32'd1);
        chk("t5_pc0", if_pc2, 32'hFFFF_FFF8);
        chk("t5_i0", if_instr2, 32'h0000_0007);
        @(negedge clk);
        chk("t5_pc1", if_pc2, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("t5_pc2", if_pc2, 32'h0000_0000);
        chk("t5_i2", if_instr2, 32'h0050_0093);
        chk("t5_err", {31'd0, misaligned_err2}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
